// File: rtl/input_conditioner_if.sv
// Bundle of raw board inputs and conditioned outputs for input_conditioner.
// master: the side that drives the raw switch/button levels and consumes the
//         conditioned operand, complement select and strobes.
// slave:  the conditioner itself.
interface input_conditioner_if #(
    parameter int N_SW = 10
);
    logic [N_SW-1:0] switches_raw;
    logic            boton_raw;
    logic [N_SW-1:0] value;
    logic            negate;
    logic            value_stb;
    logic            press_stb;

    modport master (
        output switches_raw,
        output boton_raw,
        input  value,
        input  negate,
        input  value_stb,
        input  press_stb
    );

    modport slave (
        input  switches_raw,
        input  boton_raw,
        output value,
        output negate,
        output value_stb,
        output press_stb
    );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces the slide-switch bus and the
// push button ahead of the hex-display / two's-complement stage.
//
// A raw edge held stable is visible on value/negate exactly
// DEBOUNCE_CYCLES+2 clocks later: two clocks of synchronizer, then the
// qualification counter commits on the edge where it reaches
// DEBOUNCE_CYCLES-1. value_stb/press_stb pulse in that same cycle.
//
// Optional build macro: INPUT_COND_TOGGLE_EN
//   defined   -> negate is a toggle flop flipped by every press_stb
//   undefined -> negate follows the debounced button level (PRESSED/DISARMING)
module input_conditioner #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input_conditioner_if.slave  cond_if
);

    // Counter value at which the next stable sample completes qualification.
    localparam logic [23:0] CNT_COMMIT   = 24'(DEBOUNCE_CYCLES - 2);
    // Defensive saturation ceiling for both qualification counters.
    localparam logic [23:0] CNT_SAT      = 24'(DEBOUNCE_CYCLES);
    // Raw button level when not pressed; synchronizer resets to it.
    localparam logic        BTN_IDLE_LVL = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_DISARMING = 2'd3
    } btn_state_t;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [N_SW-1:0] r_sw_meta;
    logic [N_SW-1:0] r_sw_sync;
    logic            r_btn_meta;
    logic            r_btn_sync;
    logic            w_btn_pressed;

    // Two-flop synchronizer chains for the switch bus and the button.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta  <= {N_SW{1'b0}};
            r_sw_sync  <= {N_SW{1'b0}};
            r_btn_meta <= BTN_IDLE_LVL;
            r_btn_sync <= BTN_IDLE_LVL;
        end else begin
            r_sw_meta  <= cond_if.switches_raw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= cond_if.boton_raw;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Normalize the synchronized button so that 1 always means pressed.
    assign w_btn_pressed = (BTN_ACTIVE_LOW != 0) ? ~r_btn_sync : r_btn_sync;

    // ------------------------------------------------------------------
    // Switch bus debounce (whole bus qualified as a group)
    // ------------------------------------------------------------------
    logic [N_SW-1:0] r_sw_prev;
    logic [23:0]     r_sw_cnt;
    logic [N_SW-1:0] r_value;
    logic            r_value_stb;
    logic [23:0]     w_sw_cnt_nxt;
    logic            w_sw_commit;

    // Next-count and commit decision for the switch bus.
    always_comb begin
        w_sw_cnt_nxt = r_sw_cnt;
        w_sw_commit  = 1'b0;
        if (r_sw_sync != r_sw_prev) begin
            // Bus moved this cycle: qualification restarts from scratch.
            w_sw_cnt_nxt = 24'd0;
        end else if (r_sw_sync != r_value) begin
            if (r_sw_cnt == CNT_COMMIT) begin
                w_sw_commit  = 1'b1;
                w_sw_cnt_nxt = r_sw_cnt + 24'd1;
            end else if (r_sw_cnt < CNT_SAT) begin
                w_sw_cnt_nxt = r_sw_cnt + 24'd1;
            end else begin
                w_sw_cnt_nxt = r_sw_cnt;
            end
        end else begin
            // Bus agrees with the committed operand: nothing pending, and a
            // bus that wandered back before commit leaves no residue.
            w_sw_cnt_nxt = 24'd0;
        end
    end

    // Switch debounce state, committed operand and its change strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_prev   <= {N_SW{1'b0}};
            r_sw_cnt    <= 24'd0;
            r_value     <= {N_SW{1'b0}};
            r_value_stb <= 1'b0;
        end else begin
            r_sw_prev   <= r_sw_sync;
            r_sw_cnt    <= w_sw_cnt_nxt;
            r_value_stb <= w_sw_commit;
            if (w_sw_commit) begin
                r_value <= r_sw_sync;
            end else begin
                r_value <= r_value;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button debounce FSM
    // ------------------------------------------------------------------
    btn_state_t  r_btn_state;
    btn_state_t  w_btn_state_nxt;
    logic [23:0] r_btn_cnt;
    logic [23:0] w_btn_cnt_nxt;
    logic        w_btn_press;
    logic        r_press_stb;
    logic        r_negate;
    logic        w_negate_nxt;

    // Button FSM next-state, counter and press-event logic.
    always_comb begin
        w_btn_state_nxt = r_btn_state;
        w_btn_cnt_nxt   = r_btn_cnt;
        w_btn_press     = 1'b0;
        case (r_btn_state)
            ST_RELEASED: begin
                w_btn_cnt_nxt = 24'd0;
                if (w_btn_pressed) begin
                    w_btn_state_nxt = ST_ARMING;
                end else begin
                    w_btn_state_nxt = ST_RELEASED;
                end
            end
            ST_ARMING: begin
                if (!w_btn_pressed) begin
                    w_btn_state_nxt = ST_RELEASED;
                    w_btn_cnt_nxt   = 24'd0;
                end else if (r_btn_cnt == CNT_COMMIT) begin
                    w_btn_state_nxt = ST_PRESSED;
                    w_btn_cnt_nxt   = 24'd0;
                    w_btn_press     = 1'b1;
                end else if (r_btn_cnt < CNT_SAT) begin
                    w_btn_cnt_nxt   = r_btn_cnt + 24'd1;
                end else begin
                    w_btn_cnt_nxt   = r_btn_cnt;
                end
            end
            ST_PRESSED: begin
                w_btn_cnt_nxt = 24'd0;
                if (!w_btn_pressed) begin
                    w_btn_state_nxt = ST_DISARMING;
                end else begin
                    w_btn_state_nxt = ST_PRESSED;
                end
            end
            ST_DISARMING: begin
                if (w_btn_pressed) begin
                    w_btn_state_nxt = ST_PRESSED;
                    w_btn_cnt_nxt   = 24'd0;
                end else if (r_btn_cnt == CNT_COMMIT) begin
                    w_btn_state_nxt = ST_RELEASED;
                    w_btn_cnt_nxt   = 24'd0;
                end else if (r_btn_cnt < CNT_SAT) begin
                    w_btn_cnt_nxt   = r_btn_cnt + 24'd1;
                end else begin
                    w_btn_cnt_nxt   = r_btn_cnt;
                end
            end
            default: begin
                w_btn_state_nxt = ST_RELEASED;
                w_btn_cnt_nxt   = 24'd0;
            end
        endcase
    end

`ifdef INPUT_COND_TOGGLE_EN
    // Complement mode flips on every qualified press; release is ignored.
    always_comb begin
        w_negate_nxt = r_negate;
        if (w_btn_press) begin
            w_negate_nxt = ~r_negate;
        end else begin
            w_negate_nxt = r_negate;
        end
    end
`else
    // Complement mode follows the debounced button level.
    always_comb begin
        w_negate_nxt = 1'b0;
        if ((w_btn_state_nxt == ST_PRESSED) || (w_btn_state_nxt == ST_DISARMING)) begin
            w_negate_nxt = 1'b1;
        end else begin
            w_negate_nxt = 1'b0;
        end
    end
`endif

    // Button FSM state register, counter, press strobe and negate output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_state <= ST_RELEASED;
            r_btn_cnt   <= 24'd0;
            r_press_stb <= 1'b0;
            r_negate    <= 1'b0;
        end else begin
            r_btn_state <= w_btn_state_nxt;
            r_btn_cnt   <= w_btn_cnt_nxt;
            r_press_stb <= w_btn_press;
            r_negate    <= w_negate_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign cond_if.value     = r_value;
    assign cond_if.value_stb = r_value_stb;
    assign cond_if.press_stb = r_press_stb;
    assign cond_if.negate    = r_negate;

endmodule
